// File: rtl/frame_strobe_sequencer.sv
// frame_strobe_sequencer
// Configuration-frame write controller for one fabric region. Takes one
// command (column, frame index), collects NumRows row words into FrameData,
// then raises the column enable and a registered one-hot frame strobe.
module frame_strobe_sequencer #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NumRows         = 4,
    parameter int NumCols         = 4,
    parameter int StrobeCycles    = 2,
    parameter int ColAddrW        = 2,
    parameter int FrameIdxW       = 5
) (
    input  logic                                UserCLK,
    input  logic                                resetn,
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic [ColAddrW-1:0]                 cmd_col,
    input  logic [FrameIdxW-1:0]                cmd_frame,
    input  logic                                data_valid,
    output logic                                data_ready,
    input  logic [FrameBitsPerRow-1:0]          data_word,
    output logic [NumRows*FrameBitsPerRow-1:0]  FrameData,
    output logic [MaxFramesPerCol-1:0]          FrameStrobe,
    output logic [NumCols-1:0]                  ColSelect,
    output logic                                busy,
    output logic                                err,
    output logic [15:0]                         frames_done
);

    localparam int RowW = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int SCW  = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SETUP  = 3'd2;
    localparam logic [2:0] S_STROBE = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;

    logic [2:0]                         r_state;
    logic [RowW-1:0]                    r_row_cnt;
    logic [SCW-1:0]                     r_scnt;
    logic [ColAddrW-1:0]                r_col;
    logic [FrameIdxW-1:0]               r_frame;
    logic                               r_bad;
    logic [NumRows*FrameBitsPerRow-1:0] r_frame_data;
    logic [MaxFramesPerCol-1:0]         r_strobe;
    logic [NumCols-1:0]                 r_colsel;
    logic [15:0]                        r_frames_done;
    logic                               w_cmd_bad;
    logic [NumCols-1:0]                 w_col_onehot;
    logic [MaxFramesPerCol-1:0]         w_frame_onehot;

    // Address range check and one-hot decodes of the latched command
    always_comb begin
        w_cmd_bad      = (32'(cmd_frame) >= MaxFramesPerCol) || (32'(cmd_col) >= NumCols);
        w_col_onehot   = {{(NumCols-1){1'b0}}, 1'b1} << r_col;
        w_frame_onehot = {{(MaxFramesPerCol-1){1'b0}}, 1'b1} << r_frame;
    end

    // Sequencer: handshakes, row capture, column enable, strobe timing, frame count.
    // Strobe and column enable are registered on state entry so they never glitch.
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_row_cnt     <= '0;
            r_scnt        <= '0;
            r_col         <= '0;
            r_frame       <= '0;
            r_bad         <= 1'b0;
            r_frame_data  <= '0;
            r_strobe      <= '0;
            r_colsel      <= '0;
            r_frames_done <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_col     <= cmd_col;
                        r_frame   <= cmd_frame;
                        r_bad     <= w_cmd_bad;
                        r_row_cnt <= '0;
                        r_state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (data_valid) begin
                        r_frame_data[r_row_cnt*FrameBitsPerRow +: FrameBitsPerRow] <= data_word;
                        r_row_cnt <= r_row_cnt + RowW'(1);
                        if (r_row_cnt == RowW'(NumRows-1)) begin
                            r_state  <= S_SETUP;
                            r_colsel <= r_bad ? '0 : w_col_onehot;
                        end
                    end
                end
                S_SETUP: begin
                    r_state  <= S_STROBE;
                    r_scnt   <= '0;
                    r_strobe <= r_bad ? '0 : w_frame_onehot;
                end
                S_STROBE: begin
                    if (r_scnt == SCW'(StrobeCycles-1)) begin
                        r_state  <= S_HOLD;
                        r_strobe <= '0;
                    end else begin
                        r_scnt <= r_scnt + SCW'(1);
                    end
                end
                S_HOLD: begin
                    r_state  <= S_IDLE;
                    r_colsel <= '0;
                    if (!r_bad)
                        r_frames_done <= r_frames_done + 16'd1;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_strobe <= '0;
                    r_colsel <= '0;
                end
            endcase
        end
    end

    // Status and handshake outputs decoded from registered state only
    always_comb begin
        cmd_ready   = (r_state == S_IDLE);
        data_ready  = (r_state == S_LOAD);
        busy        = (r_state != S_IDLE);
        err         = (r_state == S_HOLD) && r_bad;
        FrameData   = r_frame_data;
        FrameStrobe = r_strobe;
        ColSelect   = r_colsel;
        frames_done = r_frames_done;
    end

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// Directed bench for frame_strobe_sequencer: table of frames plus hand-written
// sequences for queued commands, mid-strobe reset and counter wrap.
module tb_frame_strobe_sequencer;

    logic          UserCLK;
    logic          resetn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_col;
    logic [4:0]    cmd_frame;
    logic          data_valid;
    logic          data_ready;
    logic [31:0]   data_word;
    logic [127:0]  FrameData;
    logic [19:0]   FrameStrobe;
    logic [3:0]    ColSelect;
    logic          busy;
    logic          err;
    logic [15:0]   frames_done;

    int checks;
    int failures;
    logic [15:0] exp_done;

    frame_strobe_sequencer dut (
        .UserCLK    (UserCLK),
        .resetn     (resetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_col    (cmd_col),
        .cmd_frame  (cmd_frame),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .data_word  (data_word),
        .FrameData  (FrameData),
        .FrameStrobe(FrameStrobe),
        .ColSelect  (ColSelect),
        .busy       (busy),
        .err        (err),
        .frames_done(frames_done)
    );

    initial UserCLK = 1'b0;
    always #5 UserCLK = ~UserCLK;

    typedef struct {
        logic [1:0]       col;
        logic [4:0]       frame;
        logic [3:0][31:0] words;
        int               gap;
        logic [3:0]       exp_sel;
        logic [19:0]      exp_stb;
        logic             exp_bad;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge UserCLK);
        #1;
    endtask

    // One complete frame; called at posedge+1 with the DUT in IDLE
    task automatic run_frame(input vec_t v);
        logic [127:0] exp_fd;
        exp_fd = v.words;
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_data_ready", data_ready, 0);
        cmd_valid = 1'b1;
        cmd_col   = v.col;
        cmd_frame = v.frame;
        tick();
        cmd_valid = 1'b0;
        chk("load_busy", busy, 1);
        chk("load_cmd_ready", cmd_ready, 0);
        for (int r = 0; r < 4; r++) begin
            if (r > 0) begin
                for (int g = 0; g < v.gap; g++) begin
                    data_valid = 1'b0;
                    tick();
                    chk("gap_no_strobe", FrameStrobe, 0);
                end
            end
            data_valid = 1'b1;
            data_word  = v.words[r];
            chk("load_data_ready", data_ready, 1);
            tick();
        end
        data_valid = 1'b0;
        chk("setup_colsel", ColSelect, v.exp_sel);
        chk("setup_strobe", FrameStrobe, 0);
        chk("setup_framedata", FrameData, exp_fd);
        for (int s = 0; s < 2; s++) begin
            tick();
            chk("strobe_value", FrameStrobe, v.exp_stb);
            chk("strobe_framedata", FrameData, exp_fd);
            chk("strobe_colsel", ColSelect, v.exp_sel);
            chk("strobe_err", err, 0);
        end
        tick();
        chk("hold_strobe", FrameStrobe, 0);
        chk("hold_err", err, v.exp_bad);
        chk("hold_colsel", ColSelect, v.exp_sel);
        chk("hold_cmd_ready", cmd_ready, 0);
        if (!v.exp_bad) exp_done = exp_done + 16'd1;
        tick();
        chk("idle_colsel", ColSelect, 0);
        chk("idle_err", err, 0);
        chk("idle_busy", busy, 0);
        chk("idle_ready_after", cmd_ready, 1);
        chk("frames_done", frames_done, exp_done);
        chk("idle_framedata_kept", FrameData, exp_fd);
    endtask

    initial begin
        logic [1:0] qc [3];
        logic [4:0] qf [3];
        int k, pulses, low_ready, bad_ready;
        logic prev_stb, hs;

        checks = 0; failures = 0; exp_done = 16'd0;
        resetn = 1'b0; cmd_valid = 1'b0; cmd_col = '0; cmd_frame = '0;
        data_valid = 1'b0; data_word = '0;

        tbl[0] = '{col:2'd1, frame:5'd5, words:{32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0},
                   gap:0, exp_sel:4'b0010, exp_stb:20'h00020, exp_bad:1'b0};
        tbl[1] = '{col:2'd1, frame:5'd5, words:{32'hB3000003, 32'hB2000002, 32'hB1000001, 32'hB0000000},
                   gap:3, exp_sel:4'b0010, exp_stb:20'h00020, exp_bad:1'b0};
        tbl[2] = '{col:2'd2, frame:5'd20, words:{32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000},
                   gap:0, exp_sel:4'b0000, exp_stb:20'h00000, exp_bad:1'b1};
        tbl[3] = '{col:2'd0, frame:5'd0, words:{32'h00000004, 32'h00000003, 32'h00000002, 32'h00000001},
                   gap:1, exp_sel:4'b0001, exp_stb:20'h00001, exp_bad:1'b0};
        tbl[4] = '{col:2'd3, frame:5'd19, words:{32'hFFFFFFFF, 32'h12345678, 32'h0, 32'h80000001},
                   gap:0, exp_sel:4'b1000, exp_stb:20'h80000, exp_bad:1'b0};

        // reset state
        #3;
        chk("rst_strobe", FrameStrobe, 0);
        chk("rst_colsel", ColSelect, 0);
        chk("rst_framedata", FrameData, 0);
        chk("rst_frames_done", frames_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        #9 resetn = 1'b1;
        tick();

        // data offered in IDLE must be refused
        data_valid = 1'b1; data_word = 32'h5555AAAA;
        tick();
        chk("idle_refuses_data", data_ready, 0);
        tick();
        data_valid = 1'b0;

        for (int i = 0; i < 5; i++) run_frame(tbl[i]);

        // three queued commands with cmd_valid and data_valid held high
        qc[0] = 2'd0; qc[1] = 2'd1; qc[2] = 2'd2;
        qf[0] = 5'd1; qf[1] = 5'd2; qf[2] = 5'd3;
        k = 0; pulses = 0; low_ready = 0; bad_ready = 0; prev_stb = 1'b0;
        for (int c = 0; c < 80; c++) begin
            cmd_valid  = (k < 3);
            cmd_col    = (k < 3) ? qc[k] : 2'd0;
            cmd_frame  = (k < 3) ? qf[k] : 5'd0;
            data_valid = 1'b1;
            data_word  = 32'hC0000000 + 32'(c);
            if (cmd_ready && busy) bad_ready++;
            if (!cmd_ready) low_ready++;
            if ((FrameStrobe != 0) && !prev_stb) pulses++;
            prev_stb = (FrameStrobe != 0);
            hs = cmd_valid && cmd_ready;
            tick();
            if (hs) k++;
        end
        cmd_valid = 1'b0; data_valid = 1'b0;
        exp_done = exp_done + 16'd3;
        chk("queue_accepts", k, 3);
        chk("queue_pulses", pulses, 3);
        chk("queue_ready_low_cycles", low_ready, 24);
        chk("queue_ready_while_busy", bad_ready, 0);
        chk("queue_frames_done", frames_done, exp_done);

        // reset during the first strobe cycle
        cmd_valid = 1'b1; cmd_col = 2'd2; cmd_frame = 5'd7;
        tick();
        cmd_valid = 1'b0;
        for (int r = 0; r < 4; r++) begin
            data_valid = 1'b1; data_word = 32'h77000000 + 32'(r);
            tick();
        end
        data_valid = 1'b0;
        tick();
        chk("rstmid_strobe_on", FrameStrobe, 20'h00080);
        #2 resetn = 1'b0;
        #1;
        chk("rstmid_strobe_drop", FrameStrobe, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_framedata", FrameData, 0);
        chk("rstmid_colsel", ColSelect, 0);
        chk("rstmid_frames_done", frames_done, 0);
        exp_done = 16'd0;
        #3 resetn = 1'b1;
        tick();
        run_frame(tbl[0]);

        // counter wrap
        force dut.r_frames_done = 16'hFFFF;
        #1 release dut.r_frames_done;
        chk("wrap_preload", frames_done, 16'hFFFF);
        exp_done = 16'hFFFF;
        run_frame(tbl[4]);
        chk("wrap_zero", frames_done, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
